imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: packs a sign-extended immediate into the immediate fields of a
// base instruction word (I/S/B/U/J formats). It flags immediates that do not fit
// the selected format, and flags invalid format codes.
//
// Pipeline: S1 registers the request. The output stage registers the packed word
// and the error flag. Both stages use valid/ready handshakes. An unstalled request
// accepted in cycle c is presented on Valid_o in cycle c+2.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   Valid_i     request valid
//   Ready_o     request can be accepted this cycle
//   ImmSrc_i    format: 000 I, 001 S, 010 B, 011 U, 100 J, others invalid
//   ImmExt_i    sign-extended immediate to pack
//   Instr_i     base instruction; bits outside the immediate fields are kept
//   Valid_o     result valid
//   Ready_i     downstream accepts the result
//   Instr_o     encoded instruction word
//   Err_o       immediate not representable, or format invalid
//   EncCount_o  results delivered (wraps)
//   ErrCount_o  results delivered with Err_o set (saturates)
module imm_encoder #(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 Valid_i,
    output logic                 Ready_o,
    input  logic [2:0]           ImmSrc_i,
    input  logic [DATAWIDTH-1:0] ImmExt_i,
    input  logic [DATAWIDTH-1:0] Instr_i,
    output logic                 Valid_o,
    input  logic                 Ready_i,
    output logic [DATAWIDTH-1:0] Instr_o,
    output logic                 Err_o,
    output logic [15:0]          EncCount_o,
    output logic [7:0]           ErrCount_o
);

    localparam logic [2:0] SrcI = 3'b000;
    localparam logic [2:0] SrcS = 3'b001;
    localparam logic [2:0] SrcB = 3'b010;
    localparam logic [2:0] SrcU = 3'b011;
    localparam logic [2:0] SrcJ = 3'b100;

    // S1 request register
    logic                 s1_valid_q;
    logic [2:0]           s1_src_q;
    logic [DATAWIDTH-1:0] s1_imm_q;
    logic [DATAWIDTH-1:0] s1_instr_q;

    // Output stage
    logic                 out_valid_q;
    logic [DATAWIDTH-1:0] out_instr_q;
    logic                 out_err_q;

    logic [15:0] enc_cnt_q, enc_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic                 accept;
    logic                 advance;
    logic                 deliver;
    logic [DATAWIDTH-1:0] packed_d;
    logic                 err_d;

    // Ready_o is a function of registered state and Ready_i only, never of Valid_i.
    assign Ready_o = !s1_valid_q || !out_valid_q || Ready_i;
    assign accept  = Valid_i && Ready_o;
    assign advance = s1_valid_q && (!out_valid_q || Ready_i);
    assign deliver = out_valid_q && Ready_i;

    // Pack S1 contents. Out-of-range immediates are still packed truncated.
    always_comb begin
        packed_d = s1_instr_q;
        err_d    = 1'b0;
        case (s1_src_q)
            SrcI: begin
                packed_d[31:20] = s1_imm_q[11:0];
                err_d = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
            end
            SrcS: begin
                packed_d[31:25] = s1_imm_q[11:5];
                packed_d[11:7]  = s1_imm_q[4:0];
                err_d = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
            end
            SrcB: begin
                packed_d[31]    = s1_imm_q[12];
                packed_d[7]     = s1_imm_q[11];
                packed_d[30:25] = s1_imm_q[10:5];
                packed_d[11:8]  = s1_imm_q[4:1];
                err_d = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) || s1_imm_q[0];
            end
            SrcU: begin
                packed_d[31:12] = s1_imm_q[19:0];
                err_d = !((&s1_imm_q[31:19]) || !(|s1_imm_q[31:19]));
            end
            SrcJ: begin
                packed_d[31]    = s1_imm_q[20];
                packed_d[19:12] = s1_imm_q[19:12];
                packed_d[20]    = s1_imm_q[11];
                packed_d[30:21] = s1_imm_q[10:1];
                err_d = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20])) || s1_imm_q[0];
            end
            default: begin
                // Invalid format: pass the base word through untouched.
                packed_d = s1_instr_q;
                err_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (deliver) begin
            enc_cnt_d = enc_cnt_q + 16'd1;
            if (out_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= '0;
            s1_imm_q   <= '0;
            s1_instr_q <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_src_q   <= ImmSrc_i;
                s1_imm_q   <= ImmExt_i;
                s1_instr_q <= Instr_i;
            end else if (advance) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            if (advance) begin
                out_valid_q <= 1'b1;
                out_instr_q <= packed_d;
                out_err_q   <= err_d;
            end else if (Ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Valid_o    = out_valid_q;
    assign Instr_o    = out_instr_q;
    assign Err_o      = out_err_q;
    assign EncCount_o = enc_cnt_q;
    assign ErrCount_o = err_cnt_q;

endmodule
